mcyc_ctrl: RTL
==============

# mcyc_ctrl

Main control FSM for the multi-cycle MIPS core. It sequences the shared datapath (one ALU, one unified memory port, IR/MDR/ALUOut registers) through the per-instruction state steps. It waits on a memory-ready handshake and counts retired instructions. It sits beside the datapath in the multi-cycle top: it takes opcode, funct and zero flag from the datapath and drives every mux select and write enable.

## Interface
- RETIRE_W, 32, width of the retired-instruction counter
- iClk  in  1  clock, all state changes on rising edge
- iRst_n  in  1  asynchronous active-low reset
- iOp  in  6  IR[31:26], valid from DECODE onward
- iFunct  in  6  IR[5:0] (passed to ALU control only; no state decisions)
- iZero  in  1  ALU zero flag, combinational from datapath
- iMemReady  in  1  memory completes the current access this cycle
- oPCWr, oIRWr, oRegWr, oMemRd, oMemWr, oIorD, oALUSrcA, oExtZero  out  1 each
- oALUSrcB  out  2  0=B, 1=const 4, 2=ext imm, 3=sext imm<<2
- oALUOp  out  2  00 add, 01 sub, 10 use funct, 11 or
- oPCSrc  out  2  0=ALU result, 1=ALUOut, 2=jump target
- oRegDst  out  2  0=rt, 1=rd, 2=$31
- oMemToReg  out  2  0=ALUOut, 1=MDR, 2=PC
- oState  out  4  current state code
- oIllegal  out  1  unsupported opcode seen in DECODE
- oRetire  out  1  one-cycle pulse when an instruction completes
- oRetired  out  RETIRE_W  retired-instruction count

## Operation
- State codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, IEXEC 9, IWB 10, JUMP 11, JAL 12. Codes 13-15 are unreachable and go to FETCH next cycle.
- Any output not listed for a state is 0.
- FETCH: MemRd, IorD=0, SrcA=0, SrcB=1, ALUOp=00, PCSrc=0. PCWr and IRWr equal iMemReady. Stay while !iMemReady, else go to DECODE.
- DECODE: SrcA=0, SrcB=3, ALUOp=00 (branch target into ALUOut). Next state by iOp:
  - 0x00 -> EXEC
  - 0x23/0x2B -> MEMADR
  - 0x04/0x05 -> BRANCH
  - 0x08/0x0D -> IEXEC
  - 0x02 -> JUMP
  - 0x03 -> JAL
  - any other opcode -> FETCH, with oIllegal=1 for this cycle only
- MEMADR: SrcA=1, SrcB=2, ALUOp=00. Next is MEMRD for lw, MEMWR for sw.
- MEMRD: MemRd, IorD=1. Wait for iMemReady, then MEMWB.
- MEMWB: RegDst=0, MemToReg=1, RegWr -> FETCH.
- MEMWR: MemWr, IorD=1. Wait for iMemReady, then FETCH.
- EXEC: SrcA=1, SrcB=0, ALUOp=10 -> ALUWB.
- ALUWB: RegDst=1, MemToReg=0, RegWr -> FETCH.
- BRANCH: SrcA=1, SrcB=0, ALUOp=01, PCSrc=1. PCWr=iZero for 0x04, ~iZero for 0x05 -> FETCH.
- IEXEC: SrcA=1, SrcB=2. ALUOp=00 for addi; ALUOp=11 with ExtZero=1 for ori -> IWB. ExtZero stays 1 in IWB for ori.
- IWB: RegDst=0, MemToReg=0, RegWr -> FETCH.
- JUMP: PCSrc=2, PCWr -> FETCH.
- JAL: PCSrc=2, PCWr, RegDst=2, MemToReg=2, RegWr -> FETCH. $31 receives the already-incremented PC.
- Retire points; oRetire=1 in that cycle and oRetired increments by 1 at the following edge:
  - MEMWB, ALUWB, BRANCH, IWB, JUMP, JAL (always)
  - MEMWR only in the cycle iMemReady=1
- Illegal opcodes do not retire. oRetired wraps modulo 2^RETIRE_W.

## Timing
- Outputs are combinational from the state register plus iOp, iZero and iMemReady (Mealy terms only as stated above).
- Cycles per instruction with zero-wait memory: lw 5, sw 4, R-type 4, addi/ori 4, beq/bne 3, j 3, jal 3, illegal 2.
- Each cycle iMemReady is low in FETCH, MEMRD or MEMWR adds one cycle. While waiting, outputs hold and no write enable other than the waited access is asserted.
- Reset (asynchronous, any state, including mid-wait):
  - state = FETCH, oRetired = 0
  - while iRst_n=0: PCWr, IRWr, RegWr, MemWr, MemRd, oRetire and oIllegal are forced to 0
  - first FETCH access starts in the first cycle after deassertion
- A wait cannot be abandoned: iOp changes during a wait are ignored (iOp is sampled only in DECODE).

## Test plan
- Reset mid-MEMRD wait (iMemReady=0): the same cycle shows oState=0, all write enables 0. After release with iMemReady=1, oIRWr=1 and oPCWr=1 in the first cycle.
- lw (iOp=0x23), iMemReady=1: oState runs 0,1,2,3,4,0. oRegWr=1 with MemToReg=1 only in state 4. oRetire pulses once; oRetired goes 0->1.
- sw with iMemReady low for 3 cycles in MEMWR: oMemWr held 4 cycles. oRetire only in the ready cycle. Total 7 cycles.
- beq with iZero=1: oPCWr=1, PCSrc=1 in BRANCH. bne with iZero=1: oPCWr=0. Both take 3 cycles and both retire.
- iOp=0x3F: the DECODE cycle has oIllegal=1, next state is FETCH, oRetired unchanged.
- jal: state 12 with PCWr=1, RegWr=1, RegDst=2, MemToReg=2. Then run 2^RETIRE_W retirements with RETIRE_W=4 and check oRetired wraps from 15 to 0.

Source files
------------

// File: rtl/mcyc_ctrl_if.sv
// Control <-> datapath bundle for the multi-cycle MIPS core.
// The ctrl modport belongs to mcyc_ctrl; the dp modport belongs to the datapath side.
interface mcyc_ctrl_if #(
  parameter int unsigned RETIRE_W = 32
);
  logic [5:0]          iOp;
  logic [5:0]          iFunct;
  logic                iZero;
  logic                iMemReady;
  logic                oPCWr;
  logic                oIRWr;
  logic                oRegWr;
  logic                oMemRd;
  logic                oMemWr;
  logic                oIorD;
  logic                oALUSrcA;
  logic                oExtZero;
  logic [1:0]          oALUSrcB;
  logic [1:0]          oALUOp;
  logic [1:0]          oPCSrc;
  logic [1:0]          oRegDst;
  logic [1:0]          oMemToReg;
  logic [3:0]          oState;
  logic                oIllegal;
  logic                oRetire;
  logic [RETIRE_W-1:0] oRetired;

  modport ctrl (
    input  iOp, iFunct, iZero, iMemReady,
    output oPCWr, oIRWr, oRegWr, oMemRd, oMemWr, oIorD, oALUSrcA, oExtZero,
           oALUSrcB, oALUOp, oPCSrc, oRegDst, oMemToReg, oState, oIllegal,
           oRetire, oRetired
  );

  modport dp (
    output iOp, iFunct, iZero, iMemReady,
    input  oPCWr, oIRWr, oRegWr, oMemRd, oMemWr, oIorD, oALUSrcA, oExtZero,
           oALUSrcB, oALUOp, oPCSrc, oRegDst, oMemToReg, oState, oIllegal,
           oRetire, oRetired
  );
endinterface

// File: rtl/mcyc_ctrl.sv
// Main control FSM of the multi-cycle MIPS core: sequences the shared datapath
// per instruction, waits on memory ready, and counts retired instructions.
module mcyc_ctrl #(
  parameter int unsigned RETIRE_W = 32
) (
  input logic       iClk,
  input logic       iRst_n,
  mcyc_ctrl_if.ctrl bus
);
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB = 4'd7,
    S_BRANCH = 4'd8,  S_IEXEC  = 4'd9,  S_IWB    = 4'd10, S_JUMP  = 4'd11,
    S_JAL    = 4'd12
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [5:0]          r_op;
  logic [RETIRE_W-1:0] r_retired;

  logic       w_pcwr, w_irwr, w_regwr, w_memrd, w_memwr, w_ill, w_ret;
  logic       w_iord, w_srca, w_extz;
  logic [1:0] w_srcb, w_aluop, w_pcsrc, w_regdst, w_m2r;
  logic       w_unused_funct;

  assign w_unused_funct = ^bus.iFunct;

  // State, latched opcode and retire counter
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state   <= S_FETCH;
      r_op      <= 6'h00;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_op <= bus.iOp;
      if (w_ret) r_retired <= r_retired + RETIRE_W'(1);
    end
  end

  always_comb begin
    w_next   = r_state;
    w_pcwr   = 1'b0;
    w_irwr   = 1'b0;
    w_regwr  = 1'b0;
    w_memrd  = 1'b0;
    w_memwr  = 1'b0;
    w_ill    = 1'b0;
    w_ret    = 1'b0;
    w_iord   = 1'b0;
    w_srca   = 1'b0;
    w_extz   = 1'b0;
    w_srcb   = 2'd0;
    w_aluop  = 2'd0;
    w_pcsrc  = 2'd0;
    w_regdst = 2'd0;
    w_m2r    = 2'd0;
    case (r_state)
      S_FETCH: begin
        w_memrd = 1'b1;
        w_srcb  = 2'd1;
        w_pcwr  = bus.iMemReady;
        w_irwr  = bus.iMemReady;
        if (bus.iMemReady) w_next = S_DECODE;
      end
      S_DECODE: begin
        w_srcb = 2'd3;
        case (bus.iOp)
          OP_RTYPE:        w_next = S_EXEC;
          OP_LW, OP_SW:    w_next = S_MEMADR;
          OP_BEQ, OP_BNE:  w_next = S_BRANCH;
          OP_ADDI, OP_ORI: w_next = S_IEXEC;
          OP_J:            w_next = S_JUMP;
          OP_JAL:          w_next = S_JAL;
          default: begin
            w_next = S_FETCH;
            w_ill  = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        w_srca = 1'b1;
        w_srcb = 2'd2;
        w_next = (r_op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        w_memrd = 1'b1;
        w_iord  = 1'b1;
        if (bus.iMemReady) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        w_m2r   = 2'd1;
        w_regwr = 1'b1;
        w_ret   = 1'b1;
        w_next  = S_FETCH;
      end
      S_MEMWR: begin
        w_memwr = 1'b1;
        w_iord  = 1'b1;
        w_ret   = bus.iMemReady;
        if (bus.iMemReady) w_next = S_FETCH;
      end
      S_EXEC: begin
        w_srca  = 1'b1;
        w_aluop = 2'd2;
        w_next  = S_ALUWB;
      end
      S_ALUWB: begin
        w_regdst = 2'd1;
        w_regwr  = 1'b1;
        w_ret    = 1'b1;
        w_next   = S_FETCH;
      end
      S_BRANCH: begin
        w_srca  = 1'b1;
        w_aluop = 2'd1;
        w_pcsrc = 2'd1;
        w_pcwr  = (r_op == OP_BEQ) ? bus.iZero : ~bus.iZero;
        w_ret   = 1'b1;
        w_next  = S_FETCH;
      end
      S_IEXEC: begin
        w_srca  = 1'b1;
        w_srcb  = 2'd2;
        w_aluop = (r_op == OP_ORI) ? 2'd3 : 2'd0;
        w_extz  = (r_op == OP_ORI);
        w_next  = S_IWB;
      end
      S_IWB: begin
        w_extz  = (r_op == OP_ORI);
        w_regwr = 1'b1;
        w_ret   = 1'b1;
        w_next  = S_FETCH;
      end
      S_JUMP: begin
        w_pcsrc = 2'd2;
        w_pcwr  = 1'b1;
        w_ret   = 1'b1;
        w_next  = S_FETCH;
      end
      S_JAL: begin
        w_pcsrc  = 2'd2;
        w_pcwr   = 1'b1;
        w_regdst = 2'd2;
        w_m2r    = 2'd2;
        w_regwr  = 1'b1;
        w_ret    = 1'b1;
        w_next   = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Enables and pulses are held low while reset is asserted
  assign bus.oPCWr     = iRst_n & w_pcwr;
  assign bus.oIRWr     = iRst_n & w_irwr;
  assign bus.oRegWr    = iRst_n & w_regwr;
  assign bus.oMemRd    = iRst_n & w_memrd;
  assign bus.oMemWr    = iRst_n & w_memwr;
  assign bus.oIllegal  = iRst_n & w_ill;
  assign bus.oRetire   = iRst_n & w_ret;
  assign bus.oIorD     = w_iord;
  assign bus.oALUSrcA  = w_srca;
  assign bus.oExtZero  = w_extz;
  assign bus.oALUSrcB  = w_srcb;
  assign bus.oALUOp    = w_aluop;
  assign bus.oPCSrc    = w_pcsrc;
  assign bus.oRegDst   = w_regdst;
  assign bus.oMemToReg = w_m2r;
  assign bus.oState    = r_state;
  assign bus.oRetired  = r_retired;
endmodule
